// File: rtl/pipelined_shifter.sv
// rtl/pipelined_shifter.sv - two-stage pipelined barrel shifter with valid/ready handshake
// Low shift-amount levels resolve in s1, high levels in s2; out_* are driven straight from s2.
module pipelined_shifter #(
  parameter int  N = 32,
  localparam int S = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_data,
  input  logic [S-1:0] in_shamt,
  input  logic [2:0]   in_op,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_data,
  output logic         out_err,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int SL = S / 2;
  localparam int SH = S - SL;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // One barrel level; amt is a constant power of two per unrolled level, always < N.
  function automatic logic [N-1:0] shift_level(input logic [N-1:0] d, input logic [2:0] op,
                                               input int amt);
    logic [N-1:0] r;
    case (op)
      OP_SLL:  r = d << amt;
      OP_SRL:  r = d >> amt;
      OP_SRA:  r = $unsigned($signed(d) >>> amt);
      OP_ROL:  r = (d << amt) | (d >> (N - amt));
      OP_ROR:  r = (d >> amt) | (d << (N - amt));
      default: r = d;
    endcase
    return r;
  endfunction

  logic          s1_valid_q;
  logic [N-1:0]  s1_data_q;
  logic [SH-1:0] s1_shamt_q;
  logic [2:0]    s1_op_q;
  logic          s2_valid_q;
  logic [N-1:0]  out_data_q;
  logic          out_err_q;

  logic          adv1;
  logic          adv2;
  logic [N-1:0]  s1_data_d;
  logic [N-1:0]  s2_data_d;
  logic          s2_err_d;

  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1 && !rst;

  always_comb begin
    s1_data_d = in_data;
    for (int k = 0; k < SL; k++) begin
      if (in_shamt[k]) s1_data_d = shift_level(s1_data_d, in_op, 1 << k);
    end
  end

  always_comb begin
    s2_data_d = s1_data_q;
    for (int k = 0; k < SH; k++) begin
      if (s1_shamt_q[k]) s2_data_d = shift_level(s2_data_d, s1_op_q, 1 << (k + SL));
    end
    s2_err_d = (s1_op_q > OP_ROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_shamt_q <= '0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid_q <= in_valid && in_ready;
        s1_data_q  <= s1_data_d;
        s1_shamt_q <= in_shamt[S-1:SL];
        s1_op_q    <= in_op;
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        out_data_q <= s2_err_d ? '0 : s2_data_d;
        out_err_q  <= s2_err_d;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign out_valid = s2_valid_q;

endmodule

// File: tb/tb_pipelined_shifter.sv
// tb/tb_pipelined_shifter.sv - randomized and directed checks of pipelined_shifter against a queue model
module tb_pipelined_shifter;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [2:0]  in_op;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;

  int total = 0;
  int bad = 0;
  int accepted = 0;
  logic [32:0] exp_q[$];

  pipelined_shifter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference: {err, data} computed from the operation definitions on a doubled word.
  function automatic logic [32:0] model(input logic [31:0] d, input logic [4:0] sh, input logic [2:0] op);
    logic [63:0] dd;
    logic [31:0] r;
    dd = {d, d};
    case (op)
      3'd0: r = d << sh;
      3'd1: r = d >> sh;
      3'd2: r = d[31] ? ~((~d) >> sh) : (d >> sh);
      3'd3: begin dd = dd << sh; r = dd[63:32]; end
      3'd4: begin dd = dd >> sh; r = dd[31:0]; end
      default: return {1'b1, 32'h0};
    endcase
    return {1'b0, r};
  endfunction

  // Per-cycle compare process, sampling 2 time units after the falling edge.
  initial begin
    logic        prev_rst;
    logic        prev_stall;
    logic [32:0] prev_out;
    logic [32:0] e;
    prev_rst = 1'b0;
    prev_stall = 1'b0;
    prev_out = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        check("in_ready_in_reset", in_ready, 0);
        exp_q.delete();
        prev_rst = 1'b1;
        prev_stall = 1'b0;
      end else begin
        if (prev_rst) begin
          check("post_reset_valid", out_valid, 0);
          check("post_reset_data", {out_err, out_data}, 0);
          check("post_reset_ready", in_ready, 1);
        end
        check("in_ready_model", in_ready, !(exp_q.size() == 2 && !out_ready));
        if (prev_stall) check("stall_hold", {out_valid, out_err, out_data}, {1'b1, prev_out});
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_out", out_valid, 0);
          end else begin
            e = exp_q[0];
            check("result", {out_err, out_data}, e);
            if (out_ready) void'(exp_q.pop_front());
          end
        end else if (exp_q.size() == 2) begin
          check("full_pipe_valid", out_valid, 1);
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(model(in_data, in_shamt, in_op));
          accepted++;
        end
        prev_stall = out_valid && !out_ready;
        prev_out = {out_err, out_data};
        prev_rst = 1'b0;
      end
    end
  end

  task automatic run1(input logic [2:0] op, input logic [31:0] d, input logic [4:0] sh,
                      input logic [31:0] ed, input logic ee, input string nm);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_data = d; in_shamt = sh; out_ready = 1'b1;
    #2 check({nm, "_acc"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #2 check({nm, "_lat1"}, out_valid, 0);
    @(negedge clk);
    #2 check({nm, "_valid"}, out_valid, 1);
    check({nm, "_data"}, out_data, ed);
    check({nm, "_err"}, out_err, ee);
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] d, input logic [4:0] sh);
    in_valid = 1'b1; in_op = op; in_data = d; in_shamt = sh;
  endtask

  initial begin
    int cyc;
    logic [31:0] rd;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2 check("reset_out_valid", out_valid, 0);
    check("reset_out_data", {out_err, out_data}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Hand-computed literals that also pin the model.
    check("model_sra", model(32'h8000_0000, 5'd4, 3'd2), {1'b0, 32'hF800_0000});
    check("model_ror", model(32'h0000_00F1, 5'd4, 3'd4), {1'b0, 32'h1000_000F});
    run1(3'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, "sll31");
    run1(3'd2, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, "sra4");
    run1(3'd1, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0, "srl4");
    run1(3'd4, 32'h0000_00F1, 5'd4,  32'h1000_000F, 1'b0, "ror4");
    run1(3'd3, 32'h8000_0001, 5'd1,  32'h0000_0003, 1'b0, "rol1");
    run1(3'd7, 32'hDEAD_BEEF, 5'd7,  32'h0,         1'b1, "rsv7");
    run1(3'd5, 32'h1234_5678, 5'd0,  32'h0,         1'b1, "rsv5");
    for (int op = 0; op < 5; op++) run1(op[2:0], 32'hA5C3_0F96, 5'd0, 32'hA5C3_0F96, 1'b0, "shamt0");

    // Backpressure: two accepted, third held until the sink opens.
    @(negedge clk); out_ready = 1'b0; drive(3'd0, 32'h1, 5'd1);
    #2 check("bp_acc1", in_ready, 1);
    @(negedge clk); drive(3'd0, 32'h1, 5'd2);
    #2 check("bp_acc2", in_ready, 1);
    @(negedge clk); drive(3'd0, 32'h1, 5'd3);
    #2 check("bp_block", in_ready, 0);
    check("bp_head", out_data, 32'h2);
    @(negedge clk);
    #2 check("bp_block2", in_ready, 0);
    @(negedge clk); out_ready = 1'b1;
    #2 check("bp_release", in_ready, 1);
    check("bp_out1", {out_valid, out_data}, {1'b1, 32'h2});
    @(negedge clk); in_valid = 1'b0;
    #2 check("bp_out2", {out_valid, out_data}, {1'b1, 32'h4});
    @(negedge clk);
    #2 check("bp_out3", {out_valid, out_data}, {1'b1, 32'h8});
    @(negedge clk);
    #2 check("bp_empty", out_valid, 0);

    // Reset with two requests in flight.
    @(negedge clk); out_ready = 1'b0; drive(3'd0, 32'h3, 5'd1);
    @(negedge clk); drive(3'd1, 32'hF0, 5'd2);
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;
    #2 check("mid_rst_ready", in_ready, 0);
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    #2 check("mid_rst_valid", out_valid, 0);
    repeat (3) @(negedge clk);
    #3 check("no_stale", out_valid, 0);

    // Random streaming with toggling handshakes and rare resets.
    accepted = 0;
    cyc = 0;
    while (accepted < 10000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      rst = ($urandom_range(0, 2999) == 0);
      case ($urandom_range(0, 5))
        0: rd = 32'h8000_0000;
        1: rd = 32'hFFFF_FFFF;
        default: rd = $urandom;
      endcase
      in_valid = ($urandom_range(0, 9) < 8);
      in_data = rd;
      in_shamt = 5'($urandom_range(0, 31));
      in_op = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 9) < 7);
    end
    check("random_budget", accepted >= 10000, 1);

    @(negedge clk); rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #3 check("drain_empty", exp_q.size(), 0);
    check("drain_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
